clint: RTL and testbench
========================

// Module: clint
// PURPOSE
//   Core-local interrupt/exception controller for the pipelined RV32I core.
//   - Sits beside EX and feeds the controller's hold_flag_clint_i input.
//   - Detects ecall, ebreak and mret from the EX instruction, plus the external
//     IRQ (and an optional timer IRQ).
//   - Sequences the mepc/mstatus/mcause CSR updates, then issues a redirect to mtvec (trap) or mepc (mret).
// PARAMETERS
//   IRQ_SYNC     1             1: irq_i passes a 2-flop synchronizer; 0: irq_i used directly
//   MTIMECMP_RST 32'hFFFF_FFFF reset value of mtimecmp (timer build only)
// PORTS
//   clk             in   1   sole clock
//   rst             in   1   synchronous, active-high reset
//   ex_valid_i      in   1   EX holds a valid instruction
//   ex_inst_i       in   32  EX instruction word
//   ex_pc_i         in   32  EX instruction address
//   irq_i           in   1   external interrupt, level-sensitive
//   csr_mtvec_i     in   32  current mtvec
//   csr_mepc_i      in   32  current mepc
//   csr_mstatus_i   in   32  current mstatus
//   clint_csr_we_o  out  1   CSR write enable; has priority over the EX write in csr
//   clint_csr_waddr_o out 12 CSR write address
//   clint_csr_wdata_o out 32 CSR write data
//   hold_flag_o     out  1   to controller; stalls IF..EX and squashes the EX instruction
//   int_assert_o    out  1   one-cycle redirect strobe to controller
//   int_addr_o      out  32  redirect target, valid when int_assert_o=1
//   timecmp_we_i    in   1   (timer build only) mtimecmp write enable
//   timecmp_wdata_i in   32  (timer build only) mtimecmp write data
// BEHAVIOUR
//   - Reset: state=IDLE; every output 0; sync flops 0; mtime=0; mtimecmp=MTIMECMP_RST.
//   - FSM states: IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, ASSERT, MRET_MST, MRET_ASSERT.
//   - Events are sampled only in IDLE. Priority: ecall/ebreak > mret > external IRQ > timer IRQ.
//   - Decode (requires ex_valid_i=1):
//     - ecall  = 32'h0000_0073
//     - ebreak = 32'h0010_0073
//     - mret   = 32'h3020_0073
//   - An IRQ is taken only when mstatus[3] (MIE)=1 and ex_valid_i=1.
//   - Trap detected in cycle T:
//     - T: hold_flag_o=1 combinationally, so the EX instruction is squashed; cause is latched.
//     - T+1: writes mepc (0x341) = ex_pc_i latched at T.
//     - T+2: writes mstatus (0x300) = csr_mstatus_i with MPIE[7]<=MIE[3] and MIE[3]<=0.
//     - T+3: writes mcause (0x342).
//       - ecall: 32'd11; ebreak: 32'd3.
//       - external IRQ: 32'h8000_000B; timer IRQ: 32'h8000_0007.
//     - T+4: int_assert_o=1, int_addr_o = {csr_mtvec_i[31:2],2'b00}.
//     - hold_flag_o=1 for T..T+4 and 0 at T+5 (back in IDLE).
//   - mret detected in cycle T:
//     - T: hold_flag_o=1.
//     - T+1: writes mstatus with MIE<=MPIE and MPIE<=1.
//     - T+2: int_assert_o=1, int_addr_o=csr_mepc_i; hold released at T+3.
//   - clint_csr_we_o is high only in the W_* and MRET_MST states; waddr/wdata are 0 otherwise.
//   - Simultaneous ecall and IRQ: the ecall is taken.
//     - The IRQ stays pending (level) but is masked by MIE=0 until mret.
//   - IRQ level changes mid-sequence are ignored and re-sampled in IDLE.
//   - Reset mid-sequence:
//     - Next cycle is IDLE with all outputs 0; no redirect is issued.
//     - CSRs already written are not rolled back.
//   - Events with ex_valid_i=0 are ignored (the bubble carries no PC to save).
// CONFIGURATION
//   - CLINT_TIMER_EN defined:
//     - Builds the 32-bit mtime counter (+1 per clk, wraps) and the mtimecmp register.
//     - Adds the timecmp_* ports.
//     - Timer IRQ = (mtime >= mtimecmp) && MIE.
//     - A timecmp_we_i write takes effect the next cycle.
//   - CLINT_TIMER_EN undefined: no timer logic and no timecmp_* ports; the timer cause is never raised.
// STRUCTURE
//   - defines.v holds:
//     - CSR addresses (`CSR_MSTATUS/MTVEC/MEPC/MCAUSE)
//     - cause codes (`CAUSE_ECALL/EBREAK/EXT_IRQ/TMR_IRQ)
//     - instruction encodings (`INST_ECALL/EBREAK/MRET)
//     - FSM state encodings.
//   - One sub-module, clint_timer (mtime/mtimecmp compare), instantiated only under CLINT_TIMER_EN.
// TESTING
//   1. ecall at pc 0x100, mtvec=0x200, mstatus=0x8:
//      -> writes mepc=0x100, mstatus=0x80, mcause=0xB at T+1..T+3
//      -> int_assert_o with int_addr_o=0x200 at T+4; hold_flag_o T..T+4.
//   2. mret with mepc=0x104, mstatus=0x80:
//      -> writes mstatus=0x88 at T+1
//      -> int_assert_o with int_addr_o=0x104 at T+2.
//   3. irq_i=1 with mstatus=0x0 -> no hold, no writes.
//      Same with mstatus=0x8, pc 0x40 -> mepc=0x40, mcause=0x8000_000B.
//   4. ecall and irq_i asserted in the same cycle -> mcause=0xB; no second trap before mret.
//   5. rst pulsed in W_MCAUSE -> next cycle all outputs 0; int_assert_o never fires.
//   6. (CLINT_TIMER_EN) mtimecmp=10, MIE=1 -> trap with mcause=0x8000_0007 once mtime>=10.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared constants for the core-local interrupt controller: CSR addresses, cause codes,
// SYSTEM instruction encodings, FSM states and the mstatus trap/return rewrites.
package clint_pkg;

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;

    localparam logic [31:0] CauseEcall  = 32'd11;
    localparam logic [31:0] CauseEbreak = 32'd3;
    localparam logic [31:0] CauseExtIrq = 32'h8000_000B;
    localparam logic [31:0] CauseTmrIrq = 32'h8000_0007;

    localparam logic [31:0] InstEcall  = 32'h0000_0073;
    localparam logic [31:0] InstEbreak = 32'h0010_0073;
    localparam logic [31:0] InstMret   = 32'h3020_0073;

    typedef enum logic [2:0] {
        StIdle,
        StWMepc,
        StWMstatus,
        StWMcause,
        StAssert,
        StMretMst,
        StMretAssert
    } clint_state_e;

    // Trap entry: MPIE <= MIE, MIE <= 0.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        return {ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
    endfunction

    // Trap return: MIE <= MPIE, MPIE <= 1.
    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        return {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
    endfunction

endpackage

// File: rtl/clint_if.sv
// Bundle between the core (EX stage, CSR file, controller) and the clint.
// The timecmp_* signals exist only when CLINT_TIMER_EN is defined.
interface clint_if;
    logic        ex_valid_i;
    logic [31:0] ex_inst_i;
    logic [31:0] ex_pc_i;
    logic        irq_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic [31:0] csr_mstatus_i;
    logic        clint_csr_we_o;
    logic [11:0] clint_csr_waddr_o;
    logic [31:0] clint_csr_wdata_o;
    logic        hold_flag_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;
`ifdef CLINT_TIMER_EN
    logic        timecmp_we_i;
    logic [31:0] timecmp_wdata_i;
`endif

    modport slave (
        input  ex_valid_i, ex_inst_i, ex_pc_i, irq_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
`ifdef CLINT_TIMER_EN
        input  timecmp_we_i, timecmp_wdata_i,
`endif
        output clint_csr_we_o, clint_csr_waddr_o, clint_csr_wdata_o, hold_flag_o,
        output int_assert_o, int_addr_o
    );

    modport master (
        output ex_valid_i, ex_inst_i, ex_pc_i, irq_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
`ifdef CLINT_TIMER_EN
        output timecmp_we_i, timecmp_wdata_i,
`endif
        input  clint_csr_we_o, clint_csr_waddr_o, clint_csr_wdata_o, hold_flag_o,
        input  int_assert_o, int_addr_o
    );
endinterface

// File: rtl/clint_timer.sv
// Free-running 32-bit mtime counter and mtimecmp register; flags mtime >= mtimecmp.
// Only instantiated when CLINT_TIMER_EN is defined.
module clint_timer #(
    parameter logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timecmp_we_i,
    input  logic [31:0] timecmp_wdata_i,
    output logic        timer_hit_o
);

    logic [31:0] mtime_q, mtime_d;
    logic [31:0] mtimecmp_q, mtimecmp_d;

    always_comb begin
        mtime_d    = mtime_q + 32'd1;
        mtimecmp_d = timecmp_we_i ? timecmp_wdata_i : mtimecmp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    assign timer_hit_o = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/clint.sv
// Core-local interrupt controller: traps on ecall/ebreak/IRQ, returns on mret, sequencing the
// CSR writes before redirecting. Optional timer interrupt built when CLINT_TIMER_EN is defined.
module clint
    import clint_pkg::*;
#(
    parameter int unsigned IRQ_SYNC = 1
`ifdef CLINT_TIMER_EN
    , parameter logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF
`endif
) (
    input  logic    clk,
    input  logic    rst,
    clint_if.slave  bus
);

    clint_state_e state_q, state_d;
    logic [31:0]  cause_q, cause_d;
    logic [31:0]  pc_q, pc_d;

    logic         irq_s;
    logic         timer_hit;
    logic         mie;
    logic         is_ecall, is_ebreak, is_mret, ext_take, tmr_take;

    logic         hold, csr_we, int_assert;
    logic [11:0]  csr_waddr;
    logic [31:0]  csr_wdata, int_addr;

    if (IRQ_SYNC != 0) begin : g_irq_sync
        logic [1:0] sync_q;
        always_ff @(posedge clk) begin
            if (rst) sync_q <= '0;
            else     sync_q <= {sync_q[0], bus.irq_i};
        end
        assign irq_s = sync_q[1];
    end else begin : g_irq_direct
        assign irq_s = bus.irq_i;
    end

`ifdef CLINT_TIMER_EN
    clint_timer #(
        .MTIMECMP_RST (MTIMECMP_RST)
    ) u_timer (
        .clk             (clk),
        .rst             (rst),
        .timecmp_we_i    (bus.timecmp_we_i),
        .timecmp_wdata_i (bus.timecmp_wdata_i),
        .timer_hit_o     (timer_hit)
    );
`else
    assign timer_hit = 1'b0;
`endif

    // A bubble in EX has no PC to save, so every event is qualified by ex_valid_i.
    assign mie       = bus.csr_mstatus_i[3];
    assign is_ecall  = bus.ex_valid_i && (bus.ex_inst_i == InstEcall);
    assign is_ebreak = bus.ex_valid_i && (bus.ex_inst_i == InstEbreak);
    assign is_mret   = bus.ex_valid_i && (bus.ex_inst_i == InstMret);
    assign ext_take  = bus.ex_valid_i && mie && irq_s;
    assign tmr_take  = bus.ex_valid_i && mie && timer_hit;

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        pc_d       = pc_q;
        hold       = 1'b0;
        csr_we     = 1'b0;
        csr_waddr  = '0;
        csr_wdata  = '0;
        int_assert = 1'b0;
        int_addr   = '0;

        case (state_q)
            StIdle: begin
                if (!rst) begin
                    if (is_ecall || is_ebreak) begin
                        hold    = 1'b1;
                        pc_d    = bus.ex_pc_i;
                        cause_d = is_ecall ? CauseEcall : CauseEbreak;
                        state_d = StWMepc;
                    end else if (is_mret) begin
                        hold    = 1'b1;
                        state_d = StMretMst;
                    end else if (ext_take) begin
                        hold    = 1'b1;
                        pc_d    = bus.ex_pc_i;
                        cause_d = CauseExtIrq;
                        state_d = StWMepc;
                    end else if (tmr_take) begin
                        hold    = 1'b1;
                        pc_d    = bus.ex_pc_i;
                        cause_d = CauseTmrIrq;
                        state_d = StWMepc;
                    end
                end
            end
            StWMepc: begin
                hold      = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = CsrMepc;
                csr_wdata = pc_q;
                state_d   = StWMstatus;
            end
            StWMstatus: begin
                hold      = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = CsrMstatus;
                csr_wdata = trap_mstatus(bus.csr_mstatus_i);
                state_d   = StWMcause;
            end
            StWMcause: begin
                hold      = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = CsrMcause;
                csr_wdata = cause_q;
                state_d   = StAssert;
            end
            StAssert: begin
                hold       = 1'b1;
                int_assert = 1'b1;
                int_addr   = bus.csr_mtvec_i & 32'hFFFF_FFFC;
                state_d    = StIdle;
            end
            StMretMst: begin
                hold      = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = CsrMstatus;
                csr_wdata = mret_mstatus(bus.csr_mstatus_i);
                state_d   = StMretAssert;
            end
            StMretAssert: begin
                hold       = 1'b1;
                int_assert = 1'b1;
                int_addr   = bus.csr_mepc_i;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cause_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.hold_flag_o       = hold;
    assign bus.clint_csr_we_o    = csr_we;
    assign bus.clint_csr_waddr_o = csr_waddr;
    assign bus.clint_csr_wdata_o = csr_wdata;
    assign bus.int_assert_o      = int_assert;
    assign bus.int_addr_o        = int_addr;

endmodule

// File: tb/tb_clint.sv
// Directed self-checking bench for clint; every output is compared once per cycle.
// Define CLINT_TIMER_EN to also exercise the timer interrupt.
module tb_clint;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    clint_if bus ();

    clint u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs mid-cycle, then advance to just after the next rising edge.
    task automatic chk(input string tag, input logic hold, input logic we, input logic [11:0] wa,
                       input logic [31:0] wd, input logic ia, input logic [31:0] iaddr);
        logic [78:0] got;
        logic [78:0] exp;
        @(negedge clk);
        exp = {hold, we, wa, wd, ia, iaddr};
        got = {bus.hold_flag_o, bus.clint_csr_we_o, bus.clint_csr_waddr_o,
               bus.clint_csr_wdata_o, bus.int_assert_o, bus.int_addr_o};
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h (hold,we,waddr,wdata,assert,addr)", tag, got, exp);
        end
        next_cycle();
    endtask

    task automatic idle(input string tag);
        chk(tag, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic trap_seq(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] ms_wr, input logic [31:0] cause,
                            input logic [31:0] vec);
        bus.ex_valid_i = 1'b1;
        bus.ex_inst_i  = inst;
        bus.ex_pc_i    = pc;
        chk({tag, ":T"}, 1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
        bus.ex_valid_i = 1'b0;
        chk({tag, ":mepc"},    1'b1, 1'b1, 12'h341, pc,    1'b0, 32'h0);
        chk({tag, ":mstatus"}, 1'b1, 1'b1, 12'h300, ms_wr, 1'b0, 32'h0);
        chk({tag, ":mcause"},  1'b1, 1'b1, 12'h342, cause, 1'b0, 32'h0);
        chk({tag, ":redirect"}, 1'b1, 1'b0, 12'h0, 32'h0, 1'b1, vec);
        idle({tag, ":release"});
    endtask

    task automatic mret_seq(input string tag, input logic [31:0] ms_wr, input logic [31:0] epc);
        bus.ex_valid_i = 1'b1;
        bus.ex_inst_i  = MRET;
        bus.ex_pc_i    = 32'h0000_0300;
        chk({tag, ":T"}, 1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
        bus.ex_valid_i = 1'b0;
        chk({tag, ":mstatus"},  1'b1, 1'b1, 12'h300, ms_wr, 1'b0, 32'h0);
        chk({tag, ":redirect"}, 1'b1, 1'b0, 12'h0, 32'h0, 1'b1, epc);
        idle({tag, ":release"});
    endtask

    initial begin
        checks             = 0;
        failures           = 0;
        rst                = 1'b1;
        bus.ex_valid_i     = 1'b0;
        bus.ex_inst_i      = NOP;
        bus.ex_pc_i        = '0;
        bus.irq_i          = 1'b0;
        bus.csr_mtvec_i    = 32'h0000_0200;
        bus.csr_mepc_i     = '0;
        bus.csr_mstatus_i  = '0;
`ifdef CLINT_TIMER_EN
        bus.timecmp_we_i    = 1'b0;
        bus.timecmp_wdata_i = '0;
`endif
        next_cycle();
        next_cycle();
        idle("reset");
        rst = 1'b0;
        idle("idle_after_reset");

        // ecall / ebreak traps
        bus.csr_mstatus_i = 32'h0000_0008;
        trap_seq("ecall", ECALL, 32'h0000_0100, 32'h0000_0080, 32'h0000_000B, 32'h0000_0200);
        bus.csr_mtvec_i   = 32'h0000_0203;
        bus.csr_mstatus_i = 32'h0000_0088;
        trap_seq("ebreak", EBREAK, 32'h0000_0120, 32'h0000_0080, 32'h0000_0003, 32'h0000_0200);
        bus.csr_mtvec_i   = 32'h0000_0200;

        // mret
        bus.csr_mstatus_i = 32'h0000_0080;
        bus.csr_mepc_i    = 32'h0000_0104;
        mret_seq("mret", 32'h0000_0088, 32'h0000_0104);
        bus.csr_mstatus_i = 32'h0000_0008;
        bus.csr_mepc_i    = 32'h0000_0110;
        mret_seq("mret_mpie0", 32'h0000_0080, 32'h0000_0110);

        // bubble carrying an ecall encoding is ignored
        bus.ex_valid_i = 1'b0;
        bus.ex_inst_i  = ECALL;
        idle("ecall_bubble");

        // external IRQ masked, then taken
        bus.csr_mstatus_i = 32'h0000_0000;
        bus.irq_i         = 1'b1;
        bus.ex_valid_i    = 1'b1;
        bus.ex_inst_i     = NOP;
        bus.ex_pc_i       = 32'h0000_0040;
        idle("irq_masked0");
        idle("irq_masked1");
        idle("irq_masked2");
        bus.csr_mstatus_i = 32'h0000_0008;
        bus.ex_valid_i    = 1'b0;
        idle("irq_bubble");
        trap_seq("irq", NOP, 32'h0000_0040, 32'h0000_0080, 32'h8000_000B, 32'h0000_0200);
        bus.irq_i = 1'b0;
        idle("irq_drain0");
        idle("irq_drain1");

        // ecall wins over a simultaneous IRQ; IRQ stays masked until mret
        bus.irq_i = 1'b1;
        idle("sync_wait0");
        idle("sync_wait1");
        trap_seq("ecall_vs_irq", ECALL, 32'h0000_0080, 32'h0000_0080, 32'h0000_000B,
                 32'h0000_0200);
        bus.csr_mstatus_i = 32'h0000_0080;
        bus.ex_valid_i    = 1'b1;
        bus.ex_inst_i     = NOP;
        bus.ex_pc_i       = 32'h0000_0084;
        idle("pending_masked0");
        idle("pending_masked1");
        bus.csr_mepc_i = 32'h0000_0080;
        mret_seq("mret_back", 32'h0000_0088, 32'h0000_0080);
        bus.csr_mstatus_i = 32'h0000_0088;
        trap_seq("irq_after_mret", NOP, 32'h0000_0084, 32'h0000_0080, 32'h8000_000B,
                 32'h0000_0200);
        bus.irq_i = 1'b0;
        idle("irq_drain2");
        idle("irq_drain3");

        // reset in W_MCAUSE aborts the redirect
        bus.csr_mstatus_i = 32'h0000_0008;
        bus.ex_valid_i    = 1'b1;
        bus.ex_inst_i     = ECALL;
        bus.ex_pc_i       = 32'h0000_0100;
        chk("rst_seq:T", 1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0);
        bus.ex_valid_i = 1'b0;
        chk("rst_seq:mepc",    1'b1, 1'b1, 12'h341, 32'h0000_0100, 1'b0, 32'h0);
        chk("rst_seq:mstatus", 1'b1, 1'b1, 12'h300, 32'h0000_0080, 1'b0, 32'h0);
        rst = 1'b1;
        chk("rst_seq:mcause",  1'b1, 1'b1, 12'h342, 32'h0000_000B, 1'b0, 32'h0);
        rst = 1'b0;
        idle("rst_seq:after0");
        idle("rst_seq:after1");

`ifdef CLINT_TIMER_EN
        // timer IRQ: mtime restarts at 0, mtimecmp=10 written in cycle 0, trap when mtime=10
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        bus.csr_mstatus_i   = 32'h0000_0008;
        bus.ex_valid_i      = 1'b1;
        bus.ex_inst_i       = NOP;
        bus.ex_pc_i         = 32'h0000_0500;
        bus.timecmp_we_i    = 1'b1;
        bus.timecmp_wdata_i = 32'd10;
        idle("tmr_k0");
        bus.timecmp_we_i = 1'b0;
        for (int k = 1; k < 10; k++) idle("tmr_before");
        trap_seq("timer", NOP, 32'h0000_0500, 32'h0000_0080, 32'h8000_0007, 32'h0000_0200);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
